// File: rtl/traffic_light_fsm.sv
// Purpose : phase controller for a main/side two-road intersection with demand latching,
//           minimum main-green hold, pedestrian walk and night flashing mode.
// Latency : state advances on the clk edge where the qualifying end pulse is high; outputs
//           are decoded from registers only, so they follow that edge. No backpressure:
//           end pulses and requests are consumed as they arrive; requests are latched.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   green_end/yellow_end/red_end    single-cycle phase-expiry pulses from the delay counter
//   side_req, ped_req               side-road sensor and pedestrian button (level or pulse)
//   night_mode                      request for flashing operation
//   state_green/yellow/red          one-hot phase-class strobes to the delay counter
//   main_lamp, side_lamp            {red, yellow, green} lamp drives
//   walk                            pedestrian walk signal
//   phase                           encoded current state, for observation
module traffic_light_fsm #(
   parameter int unsigned MIN_MAIN_GREEN = 2,
   parameter bit          FLASH_EN       = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       green_end,
   input  logic       yellow_end,
   input  logic       red_end,
   input  logic       side_req,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic       state_green,
   output logic       state_yellow,
   output logic       state_red,
   output logic [2:0] main_lamp,
   output logic [2:0] side_lamp,
   output logic       walk,
   output logic [2:0] phase
);

   localparam logic [2:0] ALL_RED_1   = 3'd0;
   localparam logic [2:0] MAIN_GREEN  = 3'd1;
   localparam logic [2:0] MAIN_YELLOW = 3'd2;
   localparam logic [2:0] ALL_RED_2   = 3'd3;
   localparam logic [2:0] SIDE_GREEN  = 3'd4;
   localparam logic [2:0] SIDE_YELLOW = 3'd5;
   localparam logic [2:0] FLASH       = 3'd6;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam logic [3:0] MIN_CNT = 4'(MIN_MAIN_GREEN);

   logic [2:0] state, state_nxt;
   logic [3:0] green_cnt, green_cnt_nxt;
   logic [4:0] green_cnt_inc;
   logic       flash_ph, flash_ph_nxt;
   logic       side_pend, ped_pend;
   logic       night_eff;
   logic       any_pend;
   logic       enter_side;

   // With flashing disabled, night_mode has no influence anywhere.
   assign night_eff = night_mode & FLASH_EN;
   assign any_pend  = side_pend | ped_pend;
   // Widened so a count of 15 cannot wrap before the comparison.
   assign green_cnt_inc = {1'b0, green_cnt} + 5'd1;

   always_comb begin
      state_nxt     = state;
      green_cnt_nxt = green_cnt;
      flash_ph_nxt  = flash_ph;
      case (state)
         ALL_RED_1: begin
            if (red_end) begin
               state_nxt     = night_eff ? FLASH : MAIN_GREEN;
               green_cnt_nxt = '0;
            end
         end
         MAIN_GREEN: begin
            if (green_end) begin
               green_cnt_nxt = (green_cnt_inc >= {1'b0, MIN_CNT}) ? MIN_CNT : green_cnt_inc[3:0];
               if ((green_cnt_inc >= {1'b0, MIN_CNT}) && (any_pend || night_eff))
                  state_nxt = MAIN_YELLOW;
            end
         end
         MAIN_YELLOW: begin
            if (yellow_end) state_nxt = ALL_RED_2;
         end
         ALL_RED_2: begin
            if (red_end) begin
               if (night_eff)     state_nxt = FLASH;
               else if (any_pend) state_nxt = SIDE_GREEN;
               else               state_nxt = ALL_RED_1;
            end
         end
         SIDE_GREEN: begin
            if (green_end) state_nxt = SIDE_YELLOW;
         end
         SIDE_YELLOW: begin
            if (yellow_end) state_nxt = ALL_RED_1;
         end
         FLASH: begin
            if (yellow_end) begin
               if (night_eff) begin
                  flash_ph_nxt = ~flash_ph;
               end else begin
                  state_nxt    = ALL_RED_1;
                  flash_ph_nxt = 1'b0;
               end
            end
         end
         default: begin
            // Encoding 7 is unreachable; recover to a safe all-red phase.
            state_nxt    = ALL_RED_1;
            flash_ph_nxt = 1'b0;
         end
      endcase
   end

   // SIDE_GREEN is only ever entered from ALL_RED_2.
   assign enter_side = (state == ALL_RED_2) && (state_nxt == SIDE_GREEN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ALL_RED_1;
         green_cnt <= '0;
         flash_ph  <= 1'b0;
         side_pend <= 1'b0;
         ped_pend  <= 1'b0;
         walk      <= 1'b0;
      end else begin
         state     <= state_nxt;
         green_cnt <= green_cnt_nxt;
         flash_ph  <= flash_ph_nxt;
         // A request arriving on the servicing edge is kept for the next cycle.
         side_pend <= side_req | (side_pend & ~enter_side);
         ped_pend  <= ped_req  | (ped_pend  & ~enter_side);
         if (enter_side)
            walk <= ped_pend;
         else if (state_nxt != SIDE_GREEN)
            walk <= 1'b0;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      state_green  = 1'b0;
      state_yellow = 1'b0;
      state_red    = 1'b1;
      main_lamp    = LAMP_RED;
      side_lamp    = LAMP_RED;
      case (state)
         MAIN_GREEN: begin
            state_green = 1'b1;
            state_red   = 1'b0;
            main_lamp   = LAMP_GRN;
         end
         MAIN_YELLOW: begin
            state_yellow = 1'b1;
            state_red    = 1'b0;
            main_lamp    = LAMP_YEL;
         end
         SIDE_GREEN: begin
            state_green = 1'b1;
            state_red   = 1'b0;
            side_lamp   = LAMP_GRN;
         end
         SIDE_YELLOW: begin
            state_yellow = 1'b1;
            state_red    = 1'b0;
            side_lamp    = LAMP_YEL;
         end
         FLASH: begin
            state_yellow = 1'b1;
            state_red    = 1'b0;
            main_lamp    = flash_ph ? LAMP_YEL : LAMP_OFF;
            side_lamp    = flash_ph ? LAMP_RED : LAMP_OFF;
         end
         default: begin
            state_green  = 1'b0;
            state_yellow = 1'b0;
            state_red    = 1'b1;
         end
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Purpose : self-checking bench for traffic_light_fsm (vector table, hand sequences,
//           randomized run against a reference model).
// Latency : inputs driven 1ns after posedge, outputs sampled 1ns after the following posedge.
// Backpressure: none.
module tb_traffic_light_fsm;

   localparam logic [2:0] R   = 3'b100;
   localparam logic [2:0] Y   = 3'b010;
   localparam logic [2:0] G   = 3'b001;
   localparam logic [2:0] OFF = 3'b000;
   localparam int         MIN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       green_end = 1'b0, yellow_end = 1'b0, red_end = 1'b0;
   logic       side_req = 1'b0, ped_req = 1'b0, night_mode = 1'b0;
   logic       state_green, state_yellow, state_red;
   logic [2:0] main_lamp, side_lamp, phase;
   logic       walk;

   int nvec = 0;
   int nmis = 0;

   traffic_light_fsm #(.MIN_MAIN_GREEN(MIN), .FLASH_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .green_end(green_end), .yellow_end(yellow_end), .red_end(red_end),
      .side_req(side_req), .ped_req(ped_req), .night_mode(night_mode),
      .state_green(state_green), .state_yellow(state_yellow), .state_red(state_red),
      .main_lamp(main_lamp), .side_lamp(side_lamp), .walk(walk), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs, g, y, r, s, p, n;
      logic [2:0] ph, ml, sl;
      logic       w;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rs, g, y, r, s, p, n,
                      input logic [2:0] ph, ml, sl, input logic w);
      vec_t v;
      v.rs = rs; v.g = g; v.y = y; v.r = r; v.s = s; v.p = p; v.n = n;
      v.ph = ph; v.ml = ml; v.sl = sl; v.w = w;
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s @%0d: got %b expected %b (t=%0t)", nm, idx, act, exp, $time);
      end
   endtask

   // Strobe class {green, yellow, red} for each phase code.
   function automatic logic [2:0] strobe_of(input int ph);
      case (ph)
         1, 4:    return 3'b100;
         2, 5, 6: return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   task automatic drive(input logic rs, g, y, r, s, p, n);
      rst = rs; green_end = g; yellow_end = y; red_end = r;
      side_req = s; ped_req = p; night_mode = n;
   endtask

   task automatic check_all(input string tag, input int idx, input int ph,
                            input logic [2:0] ml, input logic [2:0] sl, input logic w);
      check({tag, " phase"},  idx, phase, 3'(ph));
      check({tag, " main"},   idx, main_lamp, ml);
      check({tag, " side"},   idx, side_lamp, sl);
      check({tag, " walk"},   idx, {2'b00, walk}, {2'b00, w});
      check({tag, " strobe"}, idx, {state_green, state_yellow, state_red}, strobe_of(ph));
   endtask

   // Reference model: intersection rules stated on named phases with integer counters.
   int m_ph, m_cnt;
   bit m_sp, m_pp, m_fl, m_w;

   task automatic model_reset();
      m_ph = 0; m_cnt = 0; m_sp = 0; m_pp = 0; m_fl = 0; m_w = 0;
   endtask

   task automatic model_step(input bit rs, g, y, r, s, p, n);
      int  nx;
      bit  serve;
      if (rs) begin
         model_reset();
         return;
      end
      nx = m_ph;
      if (m_ph == 0 && r) begin
         nx = n ? 6 : 1;
         m_cnt = 0;
      end else if (m_ph == 1 && g) begin
         if (m_cnt + 1 >= MIN && (m_sp || m_pp || n)) nx = 2;
         m_cnt = (m_cnt + 1 > MIN) ? MIN : m_cnt + 1;
      end else if (m_ph == 2 && y) begin
         nx = 3;
      end else if (m_ph == 3 && r) begin
         nx = n ? 6 : ((m_sp || m_pp) ? 4 : 0);
      end else if (m_ph == 4 && g) begin
         nx = 5;
      end else if (m_ph == 5 && y) begin
         nx = 0;
      end else if (m_ph == 6 && y) begin
         m_fl = !m_fl;
         if (!n) begin
            nx = 0;
            m_fl = 0;
         end
      end
      serve = (nx == 4) && (m_ph != 4);
      if (serve)        m_w = m_pp;
      else if (nx != 4) m_w = 0;
      m_sp = s || (m_sp && !serve);
      m_pp = p || (m_pp && !serve);
      m_ph = nx;
   endtask

   function automatic logic [2:0] model_main();
      case (m_ph)
         1:       return G;
         2:       return Y;
         6:       return m_fl ? Y : OFF;
         default: return R;
      endcase
   endfunction

   function automatic logic [2:0] model_side();
      case (m_ph)
         4:       return G;
         5:       return Y;
         6:       return m_fl ? R : OFF;
         default: return R;
      endcase
   endfunction

   initial begin
      bit night_lvl;
      int k;
      bit rg, ry, rr, rs_, rp, rrst;

      //   rs g y r s p n   ph ml  sl  w
      add(1, 0,0,0,0,0,0,  0, R,  R,  0);    // reset state
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);    // into MAIN_GREEN
      for (int i = 0; i < 5; i++)
         add(0, 1,0,0,0,0,0,  1, G,  R,  0); // no demand: main green holds
      add(1, 0,0,0,0,0,0,  0, R,  R,  0);
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 0,0,0,0,0,0,  1, G,  R,  0);
      add(0, 0,0,0,0,0,0,  1, G,  R,  0);
      add(0, 0,0,0,1,0,0,  1, G,  R,  0);    // side_req pulse
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);    // first green_end: below min
      add(0, 1,0,0,0,0,0,  2, Y,  R,  0);
      add(0, 0,1,0,0,0,0,  3, R,  R,  0);
      add(0, 0,0,1,0,0,0,  4, R,  G,  0);
      add(0, 1,0,0,0,0,0,  5, R,  Y,  0);
      add(0, 0,1,0,0,0,0,  0, R,  R,  0);
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 0,0,0,0,1,0,  1, G,  R,  0);    // ped_req pulse
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  2, Y,  R,  0);
      add(0, 0,1,0,0,0,0,  3, R,  R,  0);
      add(0, 0,0,1,0,0,0,  4, R,  G,  1);    // walk on SIDE_GREEN entry
      add(0, 0,0,0,0,0,0,  4, R,  G,  1);
      add(0, 1,0,0,0,0,0,  5, R,  Y,  0);    // walk drops on exit
      add(0, 0,1,0,0,0,0,  0, R,  R,  0);
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 0,1,0,0,0,0,  1, G,  R,  0);    // wrong-class pulses ignored
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 0,1,1,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,1,0,0,  1, G,  R,  0);    // pend not yet latched at this edge
      add(0, 1,0,0,1,0,0,  2, Y,  R,  0);
      add(0, 0,1,0,1,0,0,  3, R,  R,  0);
      add(0, 0,0,1,1,0,0,  4, R,  G,  0);    // set wins over clear
      add(0, 1,0,0,0,0,0,  5, R,  Y,  0);
      add(0, 0,1,0,0,0,0,  0, R,  R,  0);
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  2, Y,  R,  0);    // retained side_pend yields
      add(0, 0,1,0,0,0,0,  3, R,  R,  0);
      add(0, 0,0,1,0,0,0,  4, R,  G,  0);
      add(0, 1,0,0,0,0,0,  5, R,  Y,  0);
      add(0, 0,1,0,0,0,0,  0, R,  R,  0);
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);
      add(0, 0,0,0,0,0,1,  1, G,  R,  0);
      add(0, 1,0,0,0,0,1,  2, Y,  R,  0);    // night after min green
      add(0, 0,1,0,0,0,1,  3, R,  R,  0);
      add(0, 0,0,1,0,0,1,  6, OFF,OFF,0);
      add(0, 0,1,0,0,0,1,  6, Y,  R,  0);
      add(0, 0,1,0,0,0,1,  6, OFF,OFF,0);
      add(0, 0,1,0,0,0,1,  6, Y,  R,  0);
      add(0, 0,1,0,0,0,0,  0, R,  R,  0);    // night dropped: leave FLASH
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);
      add(0, 0,0,0,1,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  1, G,  R,  0);
      add(0, 1,0,0,0,0,0,  2, Y,  R,  0);
      add(0, 0,1,0,0,0,0,  3, R,  R,  0);
      add(0, 0,0,1,0,0,0,  4, R,  G,  0);
      add(0, 0,0,0,0,0,1,  4, R,  G,  0);    // night during side: sequence completes
      add(0, 1,0,0,0,0,1,  5, R,  Y,  0);
      add(0, 0,1,0,0,0,1,  0, R,  R,  0);
      add(0, 0,0,1,0,0,1,  6, OFF,OFF,0);
      add(0, 0,1,0,0,0,0,  0, R,  R,  0);
      add(0, 0,0,1,0,0,0,  1, G,  R,  0);

      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rs, tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].n);
         @(posedge clk); #1;
         check_all("tbl", i, int'(tbl[i].ph), tbl[i].ml, tbl[i].sl, tbl[i].w);
      end

      // Asynchronous reset in SIDE_YELLOW with walk history and both demands pending.
      drive(0, 1,0,0,0,1,0); @(posedge clk); #1;
      drive(0, 1,0,0,0,0,0); @(posedge clk); #1;
      drive(0, 0,1,0,0,0,0); @(posedge clk); #1;
      drive(0, 0,0,1,0,0,0); @(posedge clk); #1;
      check_all("pre", 0, 4, R, G, 1'b1);
      drive(0, 1,0,0,1,1,0); @(posedge clk); #1;
      check_all("pre", 1, 5, R, Y, 1'b0);
      check("pre ped_pend", 1, {2'b00, dut.ped_pend}, 3'b001);
      drive(0, 0,0,0,0,0,0);
      #2 rst = 1'b1;
      #1;
      check_all("arst", 0, 0, R, R, 1'b0);
      check("arst side_pend", 0, {2'b00, dut.side_pend}, 3'b000);
      check("arst ped_pend",  0, {2'b00, dut.ped_pend},  3'b000);
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomized run against the reference model.
      model_reset();
      night_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         k  = $urandom_range(0, 99);
         rg = (k < 25);
         ry = (k >= 25 && k < 50);
         rr = (k >= 50 && k < 75);
         if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, 2);
            if (k == 0) rg = 1; else if (k == 1) ry = 1; else rr = 1;
         end
         rs_  = ($urandom_range(0, 99) < 8);
         rp   = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 99) < 2) night_lvl = !night_lvl;
         rrst = ($urandom_range(0, 499) == 0);
         drive(rrst, rg, ry, rr, rs_, rp, night_lvl);
         @(posedge clk);
         model_step(rrst, rg, ry, rr, rs_, rp, night_lvl);
         #1;
         check_all("rnd", i, m_ph, model_main(), model_side(), m_w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
